// File: rtl/payout_eval.sv
// Slot-machine payout evaluator: captures five reel symbols on start, finds the
// most frequent symbol over eight serial count cycles, then scores the bet.
//
// state | meaning
// IDLE  | waiting for start_i; result outputs hold the last evaluation
// COUNT | one candidate symbol v per cycle, v = 0..7, tracking the best count
// SCORE | apply multiplier table and load the result registers
module payout_eval #(
   parameter int BET_W = 4,
   parameter int PAY_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [BET_W-1:0] bet_i,
   input  logic [2:0]       sym1_i,
   input  logic [2:0]       sym2_i,
   input  logic [2:0]       sym3_i,
   input  logic [2:0]       sym4_i,
   input  logic [2:0]       sym5_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic             win_o,
   output logic [PAY_W-1:0] payout_o,
   output logic [2:0]       match_cnt_o,
   output logic [2:0]       match_sym_o
);

   localparam int PROD_W = BET_W + 7;
   localparam int EXT_W  = (PROD_W > PAY_W) ? PROD_W : PAY_W;

   typedef enum logic [1:0] {IDLE, COUNT, SCORE} state_t;

   state_t state, state_next;

   logic [4:0][2:0]  syms_q;
   logic [BET_W-1:0] bet_q;
   logic [2:0]       v;
   logic [2:0]       best_cnt;
   logic [2:0]       best_sym;
   logic [2:0]       n;
   logic [6:0]       base_mult;
   logic [6:0]       mult;
   logic [PROD_W-1:0] prod;
   logic [EXT_W-1:0]  prod_ext;
   logic [EXT_W-1:0]  pay_max;
   logic [PAY_W-1:0]  pay_sat;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_i) state_next = COUNT;
         COUNT:   if (v == 3'd7) state_next = SCORE;
         SCORE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      n = 3'(syms_q[0] == v) + 3'(syms_q[1] == v) + 3'(syms_q[2] == v)
        + 3'(syms_q[3] == v) + 3'(syms_q[4] == v);
   end

   always_comb begin
      base_mult = 7'd0;
      case (best_cnt)
         3'd5:    base_mult = 7'd50;
         3'd4:    base_mult = 7'd10;
         3'd3:    base_mult = 7'd3;
         default: base_mult = 7'd0;
      endcase
      mult = (best_sym == 3'd7) ? (base_mult << 1) : base_mult;
   end

   // Product may be narrower or wider than the payout; compare at the wider width.
   always_comb begin
      prod     = PROD_W'(bet_q) * PROD_W'(mult);
      prod_ext = EXT_W'(prod);
      pay_max  = EXT_W'({PAY_W{1'b1}});
      pay_sat  = (prod_ext > pay_max) ? pay_max[PAY_W-1:0] : prod_ext[PAY_W-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         syms_q      <= '0;
         bet_q       <= '0;
         v           <= 3'd0;
         best_cnt    <= 3'd0;
         best_sym    <= 3'd0;
         busy_o      <= 1'b0;
         valid_o     <= 1'b0;
         win_o       <= 1'b0;
         payout_o    <= '0;
         match_cnt_o <= 3'd0;
         match_sym_o <= 3'd0;
      end else begin
         busy_o  <= (state_next != IDLE);
         valid_o <= (state == SCORE);
         case (state)
            IDLE: begin
               if (start_i) begin
                  syms_q   <= {sym5_i, sym4_i, sym3_i, sym2_i, sym1_i};
                  bet_q    <= bet_i;
                  v        <= 3'd0;
                  best_cnt <= 3'd0;
                  best_sym <= 3'd0;
               end
            end
            COUNT: begin
               // >= lets a later (higher) symbol win a tie.
               if (n >= best_cnt) begin
                  best_cnt <= n;
                  best_sym <= v;
               end
               if (v != 3'd7) v <= v + 3'd1;
            end
            SCORE: begin
               payout_o    <= pay_sat;
               win_o       <= (pay_sat != '0);
               match_cnt_o <= best_cnt;
               match_sym_o <= best_sym;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_payout_eval.sv
// Self-checking bench for payout_eval: directed table, corner sequences and
// randomized spins against a counting reference model; PAY_W=16 and PAY_W=8 in parallel.
module tb_payout_eval;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [3:0]  bet_i = '0;
   logic [2:0]  sym1_i = '0, sym2_i = '0, sym3_i = '0, sym4_i = '0, sym5_i = '0;

   logic        busy16, valid16, win16;
   logic [15:0] pay16;
   logic [2:0]  cnt16, sym16;
   logic        busy8, valid8, win8;
   logic [7:0]  pay8;
   logic [2:0]  cnt8, sym8;

   int checks = 0;
   int failures = 0;

   int hold_p16 = 0, hold_p8 = 0, hold_cnt = 0, hold_sym = 0, hold_win = 0;

   always #5 clk_i = ~clk_i;

   payout_eval #(.BET_W(4), .PAY_W(16)) dut16 (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .bet_i(bet_i),
      .sym1_i(sym1_i), .sym2_i(sym2_i), .sym3_i(sym3_i), .sym4_i(sym4_i), .sym5_i(sym5_i),
      .busy_o(busy16), .valid_o(valid16), .win_o(win16), .payout_o(pay16),
      .match_cnt_o(cnt16), .match_sym_o(sym16));

   payout_eval #(.BET_W(4), .PAY_W(8)) dut8 (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .bet_i(bet_i),
      .sym1_i(sym1_i), .sym2_i(sym2_i), .sym3_i(sym3_i), .sym4_i(sym4_i), .sym5_i(sym5_i),
      .busy_o(busy8), .valid_o(valid8), .win_o(win8), .payout_o(pay8),
      .match_cnt_o(cnt8), .match_sym_o(sym8));

   typedef struct {
      logic [14:0] syms;
      int          bet;
      int          cnt;
      int          sym;
      int          p16;
      int          p8;
   } vec_t;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [14:0] pack5(input int a, input int b, input int c, input int d, input int e);
      return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
   endfunction

   // Reference: histogram of the five reels, scan from symbol 7 down keeping a
   // strictly larger count, so the highest symbol wins a tie.
   task automatic model(input logic [14:0] syms, input int bet,
                        output int cnt, output int sym, output int p16, output int p8);
      int hist[8];
      int mult;
      int pay;
      logic [14:0] s;
      s = syms;
      for (int i = 0; i < 8; i++) hist[i] = 0;
      for (int r = 0; r < 5; r++) hist[int'(s[r*3 +: 3])]++;
      cnt = 0;
      sym = 0;
      for (int k = 7; k >= 0; k--)
         if (hist[k] > cnt) begin
            cnt = hist[k];
            sym = k;
         end
      mult = (cnt == 5) ? 50 : (cnt == 4) ? 10 : (cnt == 3) ? 3 : 0;
      if (sym == 7) mult = mult * 2;
      pay = bet * mult;
      p16 = (pay > 65535) ? 65535 : pay;
      p8  = (pay > 255) ? 255 : pay;
   endtask

   task automatic drive_syms(input logic [14:0] s);
      sym1_i = s[2:0];
      sym2_i = s[5:3];
      sym3_i = s[8:6];
      sym4_i = s[11:9];
      sym5_i = s[14:12];
   endtask

   task automatic check_outputs(input string tag, input int p16, input int p8,
                                input int cnt, input int sym, input int win);
      chk({tag, "_pay16"}, pay16, p16);
      chk({tag, "_pay8"},  pay8,  p8);
      chk({tag, "_win16"}, win16, win);
      chk({tag, "_win8"},  win8,  win);
      chk({tag, "_cnt"},   cnt16, cnt);
      chk({tag, "_sym"},   sym16, sym);
      chk({tag, "_cnt8"},  cnt8,  cnt);
      chk({tag, "_sym8"},  sym8,  sym);
   endtask

   // Called at a negedge with the DUT idle (or in its valid cycle); returns at
   // the negedge of the valid cycle so the next start can go back-to-back.
   task automatic run_eval(input string tag, input logic [14:0] syms, input int bet,
                           input int glitch_k, input int e_cnt, input int e_sym,
                           input int e_p16, input int e_p8);
      int busy_cycles;
      int hold_bad;
      int valid_at;
      start_i = 1'b1;
      bet_i   = 4'(bet);
      drive_syms(syms);
      busy_cycles = 0;
      hold_bad    = 0;
      valid_at    = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         if (k == 1) begin
            start_i = 1'b0;
            bet_i   = 4'($urandom);
            drive_syms(15'($urandom));
         end
         if (glitch_k != 0 && k == glitch_k) begin
            start_i = 1'b1;
            bet_i   = 4'(~bet);
            drive_syms(~syms);
         end
         if (glitch_k != 0 && k == glitch_k + 1) start_i = 1'b0;
         if (busy16 && busy8) busy_cycles++;
         if (valid16 && valid8 && valid_at == 0) valid_at = k;
         if (k < 10 && (int'(pay16) != hold_p16 || int'(pay8) != hold_p8 ||
                        int'(cnt16) != hold_cnt || int'(sym16) != hold_sym ||
                        int'(win16) != hold_win))
            hold_bad++;
      end
      chk({tag, "_busy_cycles"}, busy_cycles, 9);
      chk({tag, "_valid_latency"}, valid_at, 10);
      chk({tag, "_busy_low_at_valid"}, busy16, 0);
      chk({tag, "_held_during_eval"}, hold_bad, 0);
      check_outputs(tag, e_p16, e_p8, e_cnt, e_sym, (e_p16 != 0) ? 1 : 0);
      hold_p16 = e_p16;
      hold_p8  = e_p8;
      hold_cnt = e_cnt;
      hold_sym = e_sym;
      hold_win = (e_p16 != 0) ? 1 : 0;
   endtask

   task automatic quiet_window(input string tag, input int cycles);
      int seen_valid;
      int seen_busy;
      seen_valid = 0;
      seen_busy  = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         if (valid16 || valid8) seen_valid++;
         if (busy16 || busy8) seen_busy++;
      end
      chk({tag, "_no_valid"}, seen_valid, 0);
      chk({tag, "_no_busy"}, seen_busy, 0);
   endtask

   vec_t vecs[8];

   initial begin
      int c, s, p16v, p8v;
      logic [14:0] rs;
      int rb;
      int first;

      vecs[0] = '{pack5(7,7,7,7,7),  3, 5, 7,  300, 255};
      vecs[1] = '{pack5(3,1,3,2,3),  5, 3, 3,   15,  15};
      vecs[2] = '{pack5(2,5,2,5,1),  9, 2, 5,    0,   0};
      vecs[3] = '{pack5(4,4,4,4,0),  0, 4, 4,    0,   0};
      vecs[4] = '{pack5(7,7,7,7,7), 15, 5, 7, 1500, 255};
      vecs[5] = '{pack5(7,1,7,2,7),  2, 3, 7,   12,  12};
      vecs[6] = '{pack5(6,6,6,6,6), 15, 5, 6,  750, 255};
      vecs[7] = '{pack5(0,1,2,3,4),  7, 1, 4,    0,   0};

      repeat (3) @(negedge clk_i);
      check_outputs("reset", 0, 0, 0, 0, 0);
      chk("reset_busy", busy16, 0);
      chk("reset_valid", valid16, 0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Directed table, applied back-to-back: each start lands in the previous valid cycle.
      for (int i = 0; i < 8; i++)
         run_eval($sformatf("vec%0d", i), vecs[i].syms, vecs[i].bet, 0,
                  vecs[i].cnt, vecs[i].sym, vecs[i].p16, vecs[i].p8);

      repeat (2) @(negedge clk_i);
      run_eval("glitch", pack5(0,0,0,0,0), 1, 4, 5, 0, 50, 50);
      quiet_window("glitch_after", 20);

      // Abort mid-evaluation with reset.
      start_i = 1'b1;
      bet_i   = 4'd3;
      drive_syms(pack5(7,7,7,7,7));
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         if (k == 1) start_i = 1'b0;
      end
      rst_ni = 1'b0;
      #1;
      check_outputs("midreset", 0, 0, 0, 0, 0);
      chk("midreset_busy", busy16, 0);
      chk("midreset_valid", valid16, 0);
      hold_p16 = 0; hold_p8 = 0; hold_cnt = 0; hold_sym = 0; hold_win = 0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      quiet_window("midreset_after", 20);
      check_outputs("midreset_hold", 0, 0, 0, 0, 0);

      // Random spins; reels are biased to repeat reel 1 so wins occur often.
      for (int i = 0; i < 250; i++) begin
         first = int'($urandom_range(0, 7));
         rs = '0;
         for (int r = 0; r < 5; r++) begin
            if ($urandom_range(0, 1) == 1) rs[r*3 +: 3] = 3'(first);
            else rs[r*3 +: 3] = 3'($urandom_range(0, 7));
         end
         rb = int'($urandom_range(0, 15));
         model(rs, rb, c, s, p16v, p8v);
         run_eval($sformatf("rnd%0d", i), rs, rb, 0, c, s, p16v, p8v);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
